wt_dcache_flush_ctrl: RTL and testbench

- Sequences a full invalidation of the write-through L1 dcache on a flush request.
- Stalls new miss traffic, then drains the write buffer and outstanding miss transactions.
- Walks every cache set through the cacheline write port, clearing all valid bits, then returns a single-cycle acknowledge.
- Sits between the CSR/controller flush interface and the miss unit / cache memory write port.

---
 rtl/wt_cache_pkg.sv | 15 +
 rtl/wt_dcache_flush_ctrl.sv | 130 +++++++++++++
 tb/tb_wt_dcache_flush_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/wt_cache_pkg.sv
// Shared write-through cache definitions: dcache geometry defaults and the
// flush controller state encoding.
package wt_cache_pkg;

    localparam int unsigned DCACHE_NUM_SETS  = 256;
    localparam int unsigned DCACHE_SET_ASSOC = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        INV   = 2'd2,
        ACK   = 2'd3
    } flush_state_e;

endpackage

// File: rtl/wt_dcache_flush_ctrl.sv
// Write-through dcache flush controller. On a flush request it stalls new
// misses, waits for the write buffer and miss unit to go quiet, then walks
// every set through the cacheline write port clearing all valid bits, and
// finally pulses flush_ack_o for one cycle.
// Optional: define WT_DCACHE_FLUSH_DRAIN_TIMEOUT_EN to bound the drain wait
// with DrainTimeout cycles and report a sticky drain_err_o when it expires.
module wt_dcache_flush_ctrl
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumSets      = DCACHE_NUM_SETS,
    parameter int unsigned SetAssoc     = DCACHE_SET_ASSOC,
    parameter int unsigned IdxWidth     = $clog2(NumSets)
`ifdef WT_DCACHE_FLUSH_DRAIN_TIMEOUT_EN
    ,parameter int unsigned DrainTimeout = 1024
`endif
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    output logic                flush_ack_o,
    output logic                busy_o,
    output logic                stall_o,
    input  logic                wbuffer_empty_i,
    input  logic                miss_busy_i,
    output logic                wr_cl_vld_o,
    input  logic                wr_cl_gnt_i,
    output logic [IdxWidth-1:0] wr_cl_idx_o,
    output logic [SetAssoc-1:0] wr_cl_we_o,
    output logic [SetAssoc-1:0] wr_vld_bits_o
`ifdef WT_DCACHE_FLUSH_DRAIN_TIMEOUT_EN
    ,output logic               drain_err_o
`endif
);

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumSets - 1);

    flush_state_e        state_q, state_d;
    logic [IdxWidth-1:0] idx_q, idx_d;
    logic                drain_done;

`ifdef WT_DCACHE_FLUSH_DRAIN_TIMEOUT_EN
    localparam int unsigned CntWidth = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(DrainTimeout - 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;

    assign drain_err_o = err_q;
`endif

    assign drain_done = wbuffer_empty_i & ~miss_busy_i;

    // Next-state and output decode; every output defaults to its idle value.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        flush_ack_o   = 1'b0;
        wr_cl_vld_o   = 1'b0;
        wr_cl_idx_o   = '0;
        wr_cl_we_o    = '0;
        wr_vld_bits_o = '0;
        busy_o        = (state_q != IDLE);
        // Combinational so the request cycle itself already blocks new misses.
        stall_o       = flush_i | (state_q != IDLE);
`ifdef WT_DCACHE_FLUSH_DRAIN_TIMEOUT_EN
        cnt_d         = cnt_q;
        err_d         = err_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef WT_DCACHE_FLUSH_DRAIN_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (flush_i) state_d = DRAIN;
            end
            DRAIN: begin
                idx_d = '0;
                if (drain_done) begin
                    state_d = INV;
`ifdef WT_DCACHE_FLUSH_DRAIN_TIMEOUT_EN
                end else if (cnt_q == CntMax) begin
                    // Give up waiting; invalidation proceeds but the error sticks.
                    err_d   = 1'b1;
                    state_d = INV;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
`endif
                end
            end
            INV: begin
                wr_cl_vld_o = 1'b1;
                wr_cl_idx_o = idx_q;
                wr_cl_we_o  = '1;
                // Outputs stay put without a grant; idx only moves on acceptance.
                if (wr_cl_gnt_i) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = ACK;
                    end else begin
                        idx_d = idx_q + IdxWidth'(1);
                    end
                end
            end
            ACK: begin
                flush_ack_o = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State, walk index and optional timeout registers; synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
`ifdef WT_DCACHE_FLUSH_DRAIN_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
`ifdef WT_DCACHE_FLUSH_DRAIN_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_wt_dcache_flush_ctrl.sv
// Directed bench for wt_dcache_flush_ctrl: reset values, basic walk, drain
// delay, grant backpressure, reset mid-walk, back-to-back and dropped flush
// requests, plus the drain timeout when WT_DCACHE_FLUSH_DRAIN_TIMEOUT_EN is set.
module tb_wt_dcache_flush_ctrl;
    import wt_cache_pkg::*;

    localparam int NS = 256;
    localparam int SA = 8;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic          flush_ack_o, busy_o, stall_o;
    logic          wbuffer_empty_i, miss_busy_i;
    logic          wr_cl_vld_o, wr_cl_gnt_i;
    logic [IW-1:0] wr_cl_idx_o;
    logic [SA-1:0] wr_cl_we_o, wr_vld_bits_o;
`ifdef WT_DCACHE_FLUSH_DRAIN_TIMEOUT_EN
    logic          drain_err_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    wt_dcache_flush_ctrl #(
        .NumSets (NS),
        .SetAssoc(SA)
`ifdef WT_DCACHE_FLUSH_DRAIN_TIMEOUT_EN
        ,.DrainTimeout(16)
`endif
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .flush_ack_o    (flush_ack_o),
        .busy_o         (busy_o),
        .stall_o        (stall_o),
        .wbuffer_empty_i(wbuffer_empty_i),
        .miss_busy_i    (miss_busy_i),
        .wr_cl_vld_o    (wr_cl_vld_o),
        .wr_cl_gnt_i    (wr_cl_gnt_i),
        .wr_cl_idx_o    (wr_cl_idx_o),
        .wr_cl_we_o     (wr_cl_we_o),
        .wr_vld_bits_o  (wr_vld_bits_o)
`ifdef WT_DCACHE_FLUSH_DRAIN_TIMEOUT_EN
        ,.drain_err_o   (drain_err_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one flush starting in the current (IDLE) cycle, numbered cycle 0.
    // Inputs are driven per cycle; the walk index sequence is checked on the fly.
    // Returns in the ACK cycle (or after the cycle budget expires).
    task automatic do_flush(input int drain_wait, input bit toggle_gnt, input int drop_at,
                            input bit miss_stuck, output int ack_cyc, output int vld_cnt,
                            output int first_vld);
        int exp_idx;
        exp_idx   = 0;
        ack_cyc   = -1;
        vld_cnt   = 0;
        first_vld = -1;
        for (int c = 0; c < 3000; c++) begin
            flush_i         = (drop_at >= 0 && c >= drop_at) ? 1'b0 : 1'b1;
            wbuffer_empty_i = (c > drain_wait);
            miss_busy_i     = miss_stuck;
            wr_cl_gnt_i     = toggle_gnt ? c[0] : 1'b1;
            #1;
            if (c == 0) begin
                chk("start_stall", stall_o, 1);
                chk("start_busy", busy_o, 0);
            end
            if (wr_cl_vld_o) begin
                if (first_vld < 0) first_vld = c;
                vld_cnt++;
                chk("walk_idx", wr_cl_idx_o, exp_idx);
                chk("walk_we", wr_cl_we_o, 8'hFF);
                chk("walk_vbits", wr_vld_bits_o, 0);
                if (wr_cl_gnt_i) exp_idx++;
            end
            if (flush_ack_o) begin
                ack_cyc = c;
                break;
            end
            tick();
        end
        if (ack_cyc < 0) chk("ack_timeout", 0, 1);
        chk("all_sets_granted", exp_idx, NS);
    endtask

    // Steps past the ACK cycle into IDLE with flush_i dropped and checks quiescence.
    task automatic after_ack(input string tag);
        tick();
        flush_i = 1'b0;
        #1;
        chk({tag, "_ack_pulse"}, flush_ack_o, 0);
        chk({tag, "_busy_idle"}, busy_o, 0);
        chk({tag, "_stall_idle"}, stall_o, 0);
    endtask

    initial begin
        int ack, vcnt, fv, seen_ack, guard;
        rst_i = 1'b1; flush_i = 1'b0; wbuffer_empty_i = 1'b1;
        miss_busy_i = 1'b0; wr_cl_gnt_i = 1'b0;
        tick(); tick();
        #1;
        chk("rst_ack", flush_ack_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_vld", wr_cl_vld_o, 0);
        chk("rst_idx", wr_cl_idx_o, 0);
        chk("rst_we", wr_cl_we_o, 0);
        chk("rst_vbits", wr_vld_bits_o, 0);
        flush_i = 1'b1;
        #1;
        chk("rst_stall_follows_flush", stall_o, 1);
        flush_i = 1'b0;
        rst_i = 1'b0;
        tick();

        // Basic walk: ack in cycle NumSets+2.
        do_flush(0, 1'b0, -1, 1'b0, ack, vcnt, fv);
        chk("basic_ack_cyc", ack, 258);
        chk("basic_vld_cnt", vcnt, 256);
        chk("basic_first_vld", fv, 2);
        after_ack("basic");

        // Write buffer busy for 10 cycles after the request.
        tick();
        do_flush(10, 1'b0, -1, 1'b0, ack, vcnt, fv);
        chk("drain_ack_cyc", ack, 268);
        chk("drain_first_vld", fv, 12);
        chk("drain_vld_cnt", vcnt, 256);
        after_ack("drain");

        // Grant alternates 0/1: each index held for two cycles.
        tick();
        do_flush(0, 1'b1, -1, 1'b0, ack, vcnt, fv);
        chk("bp_ack_cyc", ack, 514);
        chk("bp_vld_cnt", vcnt, 512);
        after_ack("bp");

        // Reset while index 100 is on the write port.
        tick();
        flush_i = 1'b1; wbuffer_empty_i = 1'b1; miss_busy_i = 1'b0; wr_cl_gnt_i = 1'b1;
        guard = 0;
        #1;
        while (!(wr_cl_vld_o && wr_cl_idx_o == 8'd100) && guard < 500) begin
            tick();
            #1;
            guard++;
        end
        chk("midrst_reached_idx100", wr_cl_idx_o, 100);
        rst_i = 1'b1; flush_i = 1'b0;
        tick();
        #1;
        chk("midrst_vld", wr_cl_vld_o, 0);
        chk("midrst_idx", wr_cl_idx_o, 0);
        chk("midrst_we", wr_cl_we_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_ack", flush_ack_o, 0);
        rst_i = 1'b0;
        seen_ack = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            #1;
            if (flush_ack_o || busy_o) seen_ack++;
        end
        chk("midrst_no_ack_or_busy", seen_ack, 0);
        do_flush(0, 1'b0, -1, 1'b0, ack, vcnt, fv);
        chk("midrst_restart_ack_cyc", ack, 258);

        // flush_i held one cycle past ack: a second full walk follows.
        tick();
        do_flush(0, 1'b0, -1, 1'b0, ack, vcnt, fv);
        chk("b2b_second_ack_cyc", ack, 258);
        chk("b2b_second_vld_cnt", vcnt, 256);
        after_ack("b2b");

        // flush_i dropped during INV: walk still completes with one ack.
        tick();
        do_flush(0, 1'b0, 5, 1'b0, ack, vcnt, fv);
        chk("drop_ack_cyc", ack, 258);
        chk("drop_vld_cnt", vcnt, 256);
        after_ack("drop");

`ifdef WT_DCACHE_FLUSH_DRAIN_TIMEOUT_EN
        // Miss unit never idles: timeout after 16 DRAIN cycles forces INV.
        tick();
        chk("to_err_before", drain_err_o, 0);
        do_flush(0, 1'b0, -1, 1'b1, ack, vcnt, fv);
        chk("to_first_vld", fv, 17);
        chk("to_ack_cyc", ack, 273);
        chk("to_err_set", drain_err_o, 1);
        after_ack("to");
        miss_busy_i = 1'b0;
        tick(); tick();
        #1;
        chk("to_err_sticky", drain_err_o, 1);
        rst_i = 1'b1;
        tick();
        #1;
        chk("to_err_cleared", drain_err_o, 0);
        rst_i = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
